// File: rtl/pmem_arbiter.sv
// Two-client line-miss arbiter for the 128-bit physical memory port.
// The instruction and data caches share one pmem read/write/resp handshake. Ties alternate between them.
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t            r_state;
    logic              r_last_grant;  // 0 = I, 1 = D
    logic [ADDR_W-1:0] r_lat_addr;
    logic [LINE_W-1:0] r_lat_wdata;
    logic              r_lat_write;
    logic              r_pmem_read;
    logic              r_pmem_write;

    logic w_req_i;
    logic w_req_d;
    logic w_grant_i;
    logic w_grant_d;

    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

    // On a tie the client that was not served last wins, so reset hands D the first tie.
    assign w_grant_d = w_req_d & (~w_req_i | ~r_last_grant);
    assign w_grant_i = w_req_i & ~w_grant_d;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
            r_lat_write  <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= SERVE_D;
                        r_last_grant <= 1'b1;
                        r_lat_addr   <= d_address;
                        r_lat_wdata  <= d_wdata;
                        r_lat_write  <= d_write;
                        r_pmem_read  <= ~d_write;
                        r_pmem_write <= d_write;
                    end else if (w_grant_i) begin
                        r_state      <= SERVE_I;
                        r_last_grant <= 1'b0;
                        r_lat_addr   <= i_address;
                        r_lat_write  <= 1'b0;
                        r_pmem_read  <= 1'b1;
                        r_pmem_write <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_lat_addr;
    assign pmem_wdata   = r_lat_wdata;

    // Completion is routed to the granted client only. A pmem_resp seen in IDLE reaches no one.
    assign i_resp  = (r_state == SERVE_I) & pmem_resp;
    assign d_resp  = (r_state == SERVE_D) & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter. Drivers push the expected client responses into queues.
// A monitor pops those queues on every resp and compares the returned line against a reference memory.
module tb_pmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_W1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] LINE_W2 = 128'hFEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D;
    localparam logic [127:0] LINE_W3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    typedef struct {
        logic         is_rd;
        logic [127:0] data;
    } d_exp_t;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    logic              auto_en = 1'b1;
    int                resp_lat = 2;
    logic              a_resp = 1'b0;
    logic [LINE_W-1:0] a_rdata = '0;
    logic              m_resp = 1'b0;
    logic [LINE_W-1:0] m_rdata = '0;

    assign pmem_resp  = auto_en ? a_resp : m_resp;
    assign pmem_rdata = auto_en ? a_rdata : m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] q_i[$];
    d_exp_t       q_d[$];
    cmd_t         log_q[$];

    logic [127:0] mem[logic [15:0]];
    logic [127:0] ref_mem[logic [15:0]];

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [15:0] a);
        return {4{16'hC0DE, a}};
    endfunction

    function automatic logic [127:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // Memory model: answers each command after resp_lat cycles (random 0..4 when negative).
    initial begin : responder
        int lat;
        forever begin
            @(posedge clk); #1;
            if (auto_en && (pmem_read || pmem_write)) begin
                lat = (resp_lat >= 0) ? resp_lat : int'($urandom_range(0, 4));
                repeat (lat) begin @(posedge clk); #1; end
                if (pmem_write) begin
                    mem[pmem_address] = pmem_wdata;
                    a_rdata = '0;
                end else begin
                    a_rdata = mem.exists(pmem_address) ? mem[pmem_address] : init_line(pmem_address);
                end
                a_resp = 1'b1;
                @(posedge clk); #1;
                a_resp  = 1'b0;
                a_rdata = '0;
            end
        end
    end

    // Scoreboard monitor: compares responses and checks command stability on pmem.
    initial begin : monitor
        logic         p_act, p_resp, p_rst, p_rd, p_wr;
        logic [15:0]  p_addr;
        logic [127:0] p_wd;
        logic [127:0] ei;
        d_exp_t       e;
        cmd_t         c;
        p_act = 1'b0; p_resp = 1'b0; p_rst = 1'b1; p_rd = 1'b0; p_wr = 1'b0;
        p_addr = '0; p_wd = '0;
        forever begin
            @(negedge clk);
            if (i_resp) begin
                if (q_i.size() == 0) check("i_resp_unexpected", i_resp, 0);
                else begin
                    ei = q_i.pop_front();
                    check("i_rdata", i_rdata, ei);
                end
            end else check("i_rdata_idle", i_rdata, 0);
            if (d_resp) begin
                if (q_d.size() == 0) check("d_resp_unexpected", d_resp, 0);
                else begin
                    e = q_d.pop_front();
                    if (e.is_rd) check("d_rdata", d_rdata, e.data);
                end
            end else check("d_rdata_idle", d_rdata, 0);
            check("cmd_exclusive", pmem_read & pmem_write, 0);
            if (p_act && !p_resp && !p_rst) begin
                check("cmd_held", {pmem_read, pmem_write}, {p_rd, p_wr});
                check("addr_held", pmem_address, p_addr);
                check("wdata_held", pmem_wdata, p_wd);
            end
            if ((pmem_read || pmem_write) && !p_act) begin
                c.rd = pmem_read; c.wr = pmem_write; c.addr = pmem_address; c.wdata = pmem_wdata;
                log_q.push_back(c);
            end
            p_act = pmem_read | pmem_write; p_resp = pmem_resp; p_rst = rst;
            p_rd = pmem_read; p_wr = pmem_write; p_addr = pmem_address; p_wd = pmem_wdata;
        end
    end

    task automatic wait_i(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (i_resp) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_d(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (d_resp) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_i(input logic [15:0] a, input logic [127:0] exp);
        bit ok;
        q_i.push_back(exp);
        @(posedge clk); #1;
        i_read = 1'b1; i_address = a;
        wait_i(ok);
        check("i_done", ok, 1);
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic do_d(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] wd);
        bit ok;
        d_exp_t e;
        e.is_rd = !wr;
        e.data  = wr ? '0 : ref_read(a);
        if (wr) ref_mem[a] = wd;
        q_d.push_back(e);
        @(posedge clk); #1;
        d_read = rd; d_write = wr; d_address = a; d_wdata = wd;
        wait_d(ok);
        check("d_done", ok, 1);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic check_log(input int idx, input logic rd, input logic wr, input logic [15:0] a);
        if (idx < log_q.size()) begin
            check("log_cmd", {log_q[idx].rd, log_q[idx].wr}, {rd, wr});
            check("log_addr", log_q[idx].addr, a);
        end else check("log_missing", log_q.size(), idx + 1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_i(input int n);
        bit ok;
        logic [15:0] a;
        int gap;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            a = 16'h1000 + 16'($urandom_range(0, 15)) * 16'h10;
            q_i.push_back(init_line(a));
            i_read = 1'b1; i_address = a;
            wait_i(ok);
            check("ri_done", ok, 1);
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 0) begin
                i_read = 1'b0;
                gap = int'($urandom_range(1, 3));
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        i_read = 1'b0;
    endtask

    task automatic run_d(input int n);
        bit ok;
        logic [15:0] a;
        logic [127:0] wd;
        int op, gap;
        d_exp_t e;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            op = int'($urandom_range(0, 2));
            a  = 16'h8000 + 16'($urandom_range(0, 7)) * 16'h10;
            wd = {$urandom, $urandom, $urandom, $urandom};
            e.is_rd = (op == 0);
            e.data  = (op == 0) ? ref_read(a) : '0;
            if (op != 0) ref_mem[a] = wd;
            q_d.push_back(e);
            d_read = (op != 1); d_write = (op != 0); d_address = a; d_wdata = wd;
            wait_d(ok);
            check("rd_done", ok, 1);
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 0) begin
                d_read = 1'b0; d_write = 1'b0;
                gap = int'($urandom_range(1, 3));
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin : main
        bit ok;
        int n0;
        d_exp_t e;
        mem[16'h0120] = LINE_A5;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_i_resp", i_resp, 0);
        check("rst_d_resp", d_resp, 0);

        // I-only read, memory answers 200 ns after the command appears.
        resp_lat = 20;
        n0 = log_q.size();
        q_i.push_back(LINE_A5);
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 16'h0120;
        @(negedge clk);
        check("lat_before", pmem_read, 0);
        @(negedge clk);
        check("lat_after", pmem_read, 1);
        check("lat_addr", pmem_address, 16'h0120);
        wait_i(ok);
        check("i_only_done", ok, 1);
        @(posedge clk); #1;
        i_read = 1'b0;
        check_log(n0, 1'b1, 1'b0, 16'h0120);

        // D write-back, then read the same line back.
        resp_lat = 2;
        n0 = log_q.size();
        do_d(1'b0, 1'b1, 16'h4F30, LINE_W1);
        check_log(n0, 1'b0, 1'b1, 16'h4F30);
        if (n0 < log_q.size()) check("log_wdata", log_q[n0].wdata, LINE_W1);
        do_d(1'b1, 1'b0, 16'h4F30, '0);

        // Ties: D first after reset, alternation afterwards.
        apply_reset();
        n0 = log_q.size();
        fork
            do_d(1'b1, 1'b0, 16'h4F30, '0);
            do_i(16'h0120, LINE_A5);
        join
        check_log(n0, 1'b1, 1'b0, 16'h4F30);
        check_log(n0 + 1, 1'b1, 1'b0, 16'h0120);
        n0 = log_q.size();
        fork
            do_d(1'b1, 1'b0, 16'h4F30, '0);
            do_i(16'h0120, LINE_A5);
        join
        check_log(n0, 1'b1, 1'b0, 16'h4F30);
        check_log(n0 + 1, 1'b1, 1'b0, 16'h0120);
        do_d(1'b1, 1'b0, 16'h4F30, '0);
        n0 = log_q.size();
        fork
            do_d(1'b1, 1'b0, 16'h4F30, '0);
            do_i(16'h0120, LINE_A5);
        join
        check_log(n0, 1'b1, 1'b0, 16'h0120);
        check_log(n0 + 1, 1'b1, 1'b0, 16'h4F30);

        // Inputs change while the write waits; pmem keeps the latched values.
        resp_lat = 8;
        e.is_rd = 1'b0; e.data = '0;
        q_d.push_back(e);
        ref_mem[16'h4F30] = LINE_W2;
        @(posedge clk); #1;
        d_write = 1'b1; d_address = 16'h4F30; d_wdata = LINE_W2;
        wait_cmd(ok);
        check("stab_grant", ok, 1);
        @(posedge clk); #1;
        d_address = 16'h1234; d_wdata = ~LINE_W2;
        repeat (3) begin
            @(negedge clk);
            check("stab_addr", pmem_address, 16'h4F30);
            check("stab_wdata", pmem_wdata, LINE_W2);
        end
        wait_d(ok);
        check("stab_done", ok, 1);
        @(posedge clk); #1;
        d_write = 1'b0;
        resp_lat = 2;
        do_d(1'b1, 1'b0, 16'h4F30, '0);

        // Reset two cycles after grant, then a late response that must be ignored.
        auto_en = 1'b0;
        @(posedge clk); #1;
        d_read = 1'b1; d_address = 16'h4F30;
        wait_cmd(ok);
        check("abort_grant", ok, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; d_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; m_resp = 1'b1; m_rdata = {4{$urandom}};
        @(negedge clk);
        check("abort_read", pmem_read, 0);
        check("abort_write", pmem_write, 0);
        check("late_i_resp", i_resp, 0);
        check("late_d_resp", d_resp, 0);
        @(posedge clk); #1;
        m_resp = 1'b0; m_rdata = '0;
        auto_en = 1'b1;
        do_i(16'h0120, LINE_A5);

        // d_read and d_write together behave as a write.
        n0 = log_q.size();
        do_d(1'b1, 1'b1, 16'h4F30, LINE_W3);
        check_log(n0, 1'b0, 1'b1, 16'h4F30);
        do_d(1'b1, 1'b0, 16'h4F30, '0);

        // pmem_resp held for three cycles completes only once.
        auto_en = 1'b0;
        e.is_rd = 1'b1; e.data = ref_read(16'h4F30);
        q_d.push_back(e);
        @(posedge clk); #1;
        d_read = 1'b1; d_address = 16'h4F30;
        wait_cmd(ok);
        check("held_grant", ok, 1);
        @(posedge clk); #1;
        m_resp = 1'b1; m_rdata = e.data;
        @(negedge clk);
        check("held_first", d_resp, 1);
        @(posedge clk); #1;
        d_read = 1'b0;
        @(negedge clk);
        check("held_extra", d_resp, 0);
        check("held_cmd_off", pmem_read, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("held_extra2", d_resp, 0);
        @(posedge clk); #1;
        m_resp = 1'b0; m_rdata = '0;
        auto_en = 1'b1;

        // Random concurrent traffic with random memory latency.
        resp_lat = -1;
        fork
            run_i(40);
            run_d(40);
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("q_i_drained", q_i.size(), 0);
        check("q_d_drained", q_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Initiator-side controller for the 128-bit line physical memory port.
- Arbitrates line misses from the instruction cache (read-only) and the data cache (read/write-back) onto the single pmem read/write/resp handshake.
- Latches the winning request so that address, data and command stay stable until pmem_resp. Returns the response and read line to the granted client only.

Parameters:
- ADDR_W, 16, byte address width; line offset bits [3:0] are forwarded unchanged.
- LINE_W, 128, line width in bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  instruction-cache line read request; held until i_resp.
- i_address  in  ADDR_W  instruction-cache line address.
- i_resp  out  1  one-cycle completion pulse to the instruction cache.
- i_rdata  out  LINE_W  line returned to the instruction cache; valid only when i_resp=1.
- d_read  in  1  data-cache line read request; held until d_resp.
- d_write  in  1  data-cache line write-back request; held until d_resp.
- d_address  in  ADDR_W  data-cache line address.
- d_wdata  in  LINE_W  write-back line.
- d_resp  out  1  one-cycle completion pulse to the data cache.
- d_rdata  out  LINE_W  line returned to the data cache; valid only when d_resp=1.
- pmem_read  out  1  read command to physical memory.
- pmem_write  out  1  write command to physical memory.
- pmem_address  out  ADDR_W  latched address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_resp  in  1  memory completion pulse.
- pmem_rdata  in  LINE_W  memory read line; valid with pmem_resp.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Registers: state, last_grant (0=I, 1=D), lat_addr, lat_wdata, lat_write.
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last_grant=0, lat_* = 0.
  - All outputs are 0 in the cycle after reset: pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata.
- IDLE:
  - Sample the requests: req_i=i_read, req_d=d_read|d_write.
  - Only one request present: grant it.
  - Both present: grant the client that was not last_grant (alternating). After reset D wins the first tie.
  - On grant: latch the granted address; latch d_wdata and lat_write=d_write for D (lat_write=0 for I); update last_grant; go to SERVE_x.
- d_read and d_write both asserted: treated as a write (pmem_write only).
- SERVE_x:
  - pmem_read = ~lat_write; pmem_write = lat_write.
  - pmem_address = lat_addr; pmem_wdata = lat_wdata.
  - The commands are held constant every cycle until pmem_resp.
- Latency: a request sampled at posedge N drives pmem_read/pmem_write during cycle N+1. No other added latency.
- Completion:
  - In SERVE_x with pmem_resp=1, x_resp=pmem_resp combinationally in the same cycle, and x_rdata=pmem_rdata.
  - At the next posedge, state returns to IDLE.
  - pmem_read/pmem_write deassert the cycle after pmem_resp.
- Non-granted client: resp=0 at all times. Its rdata is driven 0 except in its own response cycle.
- pmem_resp while in IDLE (late response after a reset mid-operation): ignored; neither i_resp nor d_resp asserts.
- Back-to-back:
  - A client that drops its request the cycle after its resp is not re-granted.
  - A client still asserting in IDLE is treated as a new request.
  - Minimum turnaround is one IDLE cycle between transactions.
- Requests arriving while in SERVE_x are not sampled until IDLE. Requests are never lost while they are held.
- Reset mid-transaction: abort to IDLE next cycle, deassert pmem_read/pmem_write, no client response.
- pmem_resp held high for more than one cycle: only the first cycle completes the transaction; extra cycles fall in IDLE and are ignored.

Test Plan:
- I-only read: i_read=1, i_address=16'h0120; memory responds after 200 ns with rdata=128'hA5..A5 -> pmem_read=1 from the next cycle; pmem_address=16'h0120 stable; i_resp=1 for exactly 1 cycle with i_rdata=128'hA5..A5; d_resp stays 0.
- D write-back: d_write=1, d_address=16'h4F30, d_wdata=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 -> pmem_write=1, pmem_read=0; the line reads back identically via a subsequent d_read to 16'h4F30; d_resp pulses once per transaction.
- Simultaneous after reset: i_read and d_read asserted in the same cycle -> D served first, then I. Assert both again -> D then I again (alternation), pmem_address switching 16'h4F30 then 16'h0120.
- Input stability: change d_address/d_wdata while SERVE_D is waiting -> pmem_address/pmem_wdata remain the latched values.
- Reset mid-operation: assert rst two cycles after grant -> pmem_read=0 next cycle. The late pmem_resp produces no i_resp/d_resp, and the next request is served normally.
- Read+write together: d_read=d_write=1 -> pmem_write=1 only, and d_resp pulses once.
